// File: rtl/miller_pkg.sv
// Shared types and constants for the Miller receive path: FSM states, frame status codes and CRC-16/CCITT constants.
package miller_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HUNT = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_NO_PRE   = 2'd1,
        ST_CODE_ERR = 2'd2,
        ST_CRC_ERR  = 2'd3
    } rx_status_e;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    // One MSB-first step of the CCITT polynomial division.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/miller_crc16.sv
// Serial CRC-16/CCITT over the received data bits; crc_next_o is the value the register takes at the next edge.
module miller_crc16
    import miller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_next_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC16_PRESET;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    assign crc_next_o = crc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC16_PRESET;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/miller_rx_ctrl.sv
// Receive-path sequencer for the Miller tag-reply decoder: arm, preamble hunt, bit framing, status-tagged hand-off.
// Define MILLER_RX_CRC16_EN to add the CRC-16 residue check on otherwise good frames.
module miller_rx_ctrl
    import miller_pkg::*;
#(
    parameter int                 MAX_BITS    = 128,
    parameter int                 PRE_LEN     = 6,
    parameter logic [PRE_LEN-1:0] PRE_PATTERN = 6'b010111,
    parameter int                 T_PRE_CYC   = 4096,
    parameter int                 GAP_CYC     = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
    input  logic                          abort,
    input  logic                          sym_valid,
    input  logic                          sym_bit,
    input  logic                          sym_err,
    output logic                          demod_en,
    output logic                          busy,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [MAX_BITS-1:0]           frame_data,
    output logic [$clog2(MAX_BITS+1)-1:0] frame_len,
    output logic [1:0]                    frame_status
);

    localparam int LEN_W  = $clog2(MAX_BITS + 1);
    localparam int TMR_W  = $clog2((T_PRE_CYC > GAP_CYC) ? T_PRE_CYC : GAP_CYC);
    localparam int PCNT_W = $clog2(PRE_LEN + 1);

    localparam logic [TMR_W-1:0]  PRE_TMO  = TMR_W'(T_PRE_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_TMO  = TMR_W'(GAP_CYC - 1);
    localparam logic [PCNT_W-1:0] PRE_LAST = PCNT_W'(PRE_LEN - 1);
    localparam logic [PCNT_W-1:0] PRE_FULL = PCNT_W'(PRE_LEN);
    localparam logic [LEN_W-1:0]  LEN_LAST = LEN_W'(MAX_BITS - 1);

    rx_state_e             state_q, state_d;
    rx_status_e            status_q, status_d, ok_status;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [PRE_LEN-1:0]    win_q, win_d, win_shift;
    logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
    logic [MAX_BITS-1:0]   data_q, data_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  pre_hit;
    logic                  term_ok;

    // The window only qualifies once PRE_LEN bits have arrived since arm or the last code violation.
    assign win_shift = {win_q[PRE_LEN-2:0], sym_bit};
    assign pre_hit   = sym_valid && !sym_err && (pcnt_q >= PRE_LAST) && (win_shift == PRE_PATTERN);

`ifdef MILLER_RX_CRC16_EN
    localparam logic [LEN_W-1:0] MIN_CRC_LEN = LEN_W'(16);

    logic        crc_init, crc_en;
    logic [15:0] crc_next;

    assign crc_init = (state_q == S_HUNT) && !abort && pre_hit;
    assign crc_en   = (state_q == S_DATA) && !abort && sym_valid && !sym_err;

    miller_crc16 u_crc (
        .clk        (clk),
        .rst        (rst),
        .init_i     (crc_init),
        .en_i       (crc_en),
        .bit_i      (sym_bit),
        .crc_next_o (crc_next)
    );
`endif

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        timer_d   = timer_q;
        win_d     = win_q;
        pcnt_d    = pcnt_q;
        data_d    = data_q;
        len_d     = len_q;
        term_ok   = 1'b0;
        ok_status = ST_OK;

        case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    state_d  = S_HUNT;
                    status_d = ST_OK;
                    timer_d  = '0;
                    win_d    = '0;
                    pcnt_d   = '0;
                    data_d   = '0;
                    len_d    = '0;
                end
            end
            S_HUNT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (sym_err) begin
                        win_d  = '0;
                        pcnt_d = '0;
                    end else if (sym_valid) begin
                        win_d = win_shift;
                        if (pcnt_q != PRE_FULL) pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                    if (pre_hit) begin
                        state_d = S_DATA;
                        timer_d = '0;
                    end else if (timer_q == PRE_TMO) begin
                        state_d  = S_DONE;
                        status_d = ST_NO_PRE;
                        len_d    = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (sym_err) begin
                    state_d  = S_DONE;
                    status_d = ST_CODE_ERR;
                end else if (sym_valid) begin
                    data_d  = {data_q[MAX_BITS-2:0], sym_bit};
                    len_d   = len_q + LEN_W'(1);
                    timer_d = '0;
                    if (len_q == LEN_LAST) begin
                        state_d = S_DONE;
                        term_ok = 1'b1;
                    end
                end else if (timer_q == GAP_TMO) begin
                    state_d = S_DONE;
                    if (len_q == '0) status_d = ST_CODE_ERR;
                    else             term_ok  = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                if (frame_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MILLER_RX_CRC16_EN
        if (len_d < MIN_CRC_LEN || crc_next != CRC16_RESIDUE) ok_status = ST_CRC_ERR;
`endif
        if (term_ok) status_d = ok_status;
    end

    // NOTE: the frame buffer is reset too, because its contents are visible on frame_data straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            timer_q  <= '0;
            win_q    <= '0;
            pcnt_q   <= '0;
            data_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            timer_q  <= timer_d;
            win_q    <= win_d;
            pcnt_q   <= pcnt_d;
            data_q   <= data_d;
            len_q    <= len_d;
        end
    end

    assign demod_en     = (state_q == S_HUNT) || (state_q == S_DATA);
    assign busy         = demod_en;
    assign frame_valid  = (state_q == S_DONE);
    assign frame_data   = data_q;
    assign frame_len    = len_q;
    assign frame_status = status_q;

endmodule

// File: tb/tb_miller_rx_ctrl.sv
// Scoreboard bench for miller_rx_ctrl: symbol streams are scored by a list-level reference model, a monitor checks frames.
// Define MILLER_RX_CRC16_EN for both bench and RTL to exercise the CRC status.
module tb_miller_rx_ctrl;

    localparam int          MAX_BITS  = 128;
    localparam int          PRE_LEN   = 6;
    localparam logic [5:0]  PRE_PAT   = 6'b010111;
    localparam int          T_PRE_CYC = 4096;
    localparam int          GAP_CYC   = 64;
    localparam int          SYM_ERR   = 2;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   len;
        logic [1:0]   status;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         arm = 1'b0;
    logic         abort = 1'b0;
    logic         sym_valid = 1'b0;
    logic         sym_bit = 1'b0;
    logic         sym_err = 1'b0;
    logic         demod_en, busy, frame_valid;
    logic         frame_ready;
    logic [127:0] frame_data;
    logic [7:0]   frame_len;
    logic [1:0]   frame_status;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   force_hold = -1;
    exp_t sb[$];

    miller_rx_ctrl #(
        .MAX_BITS    (MAX_BITS),
        .PRE_LEN     (PRE_LEN),
        .PRE_PATTERN (PRE_PAT),
        .T_PRE_CYC   (T_PRE_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .abort        (abort),
        .sym_valid    (sym_valid),
        .sym_bit      (sym_bit),
        .sym_err      (sym_err),
        .demod_en     (demod_en),
        .busy         (busy),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_len    (frame_len),
        .frame_status (frame_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input bit q[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (q[i]) begin
            logic fb = c[15] ^ q[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic bit tail_is_pre(input bit h[$]);
        int base = h.size() - PRE_LEN;
        for (int k = 0; k < PRE_LEN; k++)
            if (h[base + k] != PRE_PAT[PRE_LEN-1-k]) return 1'b0;
        return 1'b1;
    endfunction

    // Frame the reply from the symbol list alone: first preamble since the last error opens the frame.
    function automatic exp_t model(input int s[$]);
        exp_t e;
        bit   hist[$];
        bit   data[$];
        bit   in_data = 1'b0;
        bit   err_end = 1'b0;
        bit   full    = 1'b0;
        e.data = '0;
        for (int i = 0; i < s.size() && !err_end && !full; i++) begin
            if (!in_data) begin
                if (s[i] == SYM_ERR) hist.delete();
                else begin
                    hist.push_back(s[i][0]);
                    if (hist.size() >= PRE_LEN && tail_is_pre(hist)) in_data = 1'b1;
                end
            end else if (s[i] == SYM_ERR) begin
                err_end = 1'b1;
            end else begin
                data.push_back(s[i][0]);
                if (data.size() == MAX_BITS) full = 1'b1;
            end
        end
        foreach (data[i]) e.data[data.size()-1-i] = data[i];
        e.len = 8'(data.size());
        if (err_end || data.size() == 0) e.status = 2'd2;
        else begin
            e.status = 2'd0;
`ifdef MILLER_RX_CRC16_EN
            if (data.size() < 16 || crc_of(data) != 16'h1D0F) e.status = 2'd3;
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input int v);
        if (v == SYM_ERR) sym_err = 1'b1;
        else begin
            sym_valid = 1'b1;
            sym_bit   = v[0];
        end
        tick();
        sym_valid = 1'b0;
        sym_err   = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy && !frame_valid) return;
            tick();
        end
        n_checks++;
        n_fails++;
        $display("FAIL idle_timeout: DUT still busy or holding a frame after 400 cycles");
    endtask

    task automatic push_pre(inout int s[$]);
        for (int k = PRE_LEN - 1; k >= 0; k--) s.push_back(int'(PRE_PAT[k]));
    endtask

    task automatic run_stream(input int s[$], input int max_idle, input int arm_at, input bit gap_timing);
        sb.push_back(model(s));
        do_arm();
        check("demod_en_after_arm", demod_en, 1);
        foreach (s[i]) begin
            send_sym(s[i]);
            if (i == arm_at) do_arm();
            repeat ($urandom_range(0, max_idle)) tick();
        end
        if (gap_timing) begin
            repeat (GAP_CYC - 1) tick();
            check("gap_not_yet_expired", frame_valid, 0);
            tick();
            check("gap_expired_frame_valid", frame_valid, 1);
        end else begin
            repeat (GAP_CYC + 2) tick();
        end
        wait_idle();
    endtask

    initial begin : monitor
        exp_t snap;
        bit   have = 1'b0;
        int   hold = 0;
        frame_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            frame_ready = 1'b0;
            if (frame_valid) begin
                if (!have) begin
                    have = 1'b1;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_frame: frame_valid=1 with no frame expected");
                        snap = '{data: '0, len: '0, status: '0};
                    end else begin
                        snap = sb.pop_front();
                        check("frame_data", frame_data, snap.data);
                        check("frame_len", frame_len, snap.len);
                        check("frame_status", frame_status, snap.status);
                        check("demod_en_in_done", demod_en, 0);
                    end
                    hold = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
                    force_hold = -1;
                end else begin
                    check("stable_data", frame_data, snap.data);
                    check("stable_len", frame_len, snap.len);
                    check("stable_status", frame_status, snap.status);
                end
                if (hold == 0) frame_ready = 1'b1;
                else hold--;
            end else begin
                have = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   s[$];
        bit   pay[$];
        logic [15:0] nc;

        repeat (3) tick();
        check("rst_frame_valid", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_demod_en", demod_en, 0);
        check("rst_frame_data", frame_data, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_frame_status", frame_status, 0);
        rst = 1'b0;
        tick();

        // Basic frame, arm ignored mid-frame, exact gap timeout.
        s.delete();
        push_pre(s);
        s.push_back(1); s.push_back(0); s.push_back(1); s.push_back(1);
        run_stream(s, 0, PRE_LEN - 1, 1'b1);

        // Preamble timeout.
        sb.push_back('{data: '0, len: 8'd0, status: 2'd1});
        do_arm();
        repeat (T_PRE_CYC - 1) tick();
        check("hunt_not_timed_out", frame_valid, 0);
        check("hunt_busy", busy, 1);
        tick();
        check("hunt_timeout_valid", frame_valid, 1);
        check("hunt_timeout_demod_off", demod_en, 0);
        wait_idle();

        // Code error after three data bits.
        s.delete();
        push_pre(s);
        s.push_back(1); s.push_back(1); s.push_back(0); s.push_back(SYM_ERR);
        run_stream(s, 2, -1, 1'b0);

        // Error inside a partial preamble, then a clean preamble.
        s.delete();
        s.push_back(0); s.push_back(1); s.push_back(0); s.push_back(1); s.push_back(SYM_ERR);
        push_pre(s);
        for (int i = 0; i < 20; i++) s.push_back(int'($urandom_range(0, 1)));
        run_stream(s, 3, -1, 1'b0);

        // Full buffer with two surplus bits, a held consumer and an arm in DONE.
        s.delete();
        push_pre(s);
        for (int i = 0; i < MAX_BITS + 2; i++) s.push_back(int'($urandom_range(0, 1)));
        force_hold = 10;
        run_stream(s, 0, PRE_LEN + MAX_BITS + 1, 1'b0);

        // Abort during DATA produces no frame.
        do_arm();
        s.delete();
        push_pre(s);
        for (int i = 0; i < 5; i++) s.push_back(1);
        foreach (s[i]) send_sym(s[i]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_demod_en", demod_en, 0);
        repeat (GAP_CYC + 4) tick();
        check("abort_no_frame", frame_valid, 0);

        // Reset in DATA discards the partial frame.
        do_arm();
        foreach (s[i]) if (i < PRE_LEN + 3) send_sym(s[i]);
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_demod_en", demod_en, 0);
        check("midrst_frame_data", frame_data, 0);
        check("midrst_frame_len", frame_len, 0);
        check("midrst_frame_status", frame_status, 0);
        rst = 1'b0;
        tick();

        // arm and abort together in IDLE.
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_idle_busy", busy, 0);
        tick();
        check("arm_abort_idle_demod", demod_en, 0);

        // Payload with a correct inverted CRC, then the same frame with one payload bit flipped.
        for (int flip = 0; flip < 2; flip++) begin
            pay.delete();
            for (int i = 0; i < 16; i++) pay.push_back(1'($urandom_range(0, 1)));
            nc = ~crc_of(pay);
            s.delete();
            push_pre(s);
            foreach (pay[i]) s.push_back(int'(pay[i]));
            for (int k = 15; k >= 0; k--) s.push_back(int'(nc[k]));
            if (flip == 1) s[PRE_LEN + 3] = 1 - s[PRE_LEN + 3];
            run_stream(s, 2, -1, 1'b0);
        end

        // Random replies: junk with errors, a preamble, then data with occasional errors.
        for (int t = 0; t < 40; t++) begin
            int n_junk = $urandom_range(0, 8);
            int n_data = (t % 10 == 9) ? MAX_BITS + 1 : $urandom_range(0, 24);
            s.delete();
            for (int i = 0; i < n_junk; i++)
                s.push_back(($urandom_range(0, 7) == 0) ? SYM_ERR : int'($urandom_range(0, 1)));
            push_pre(s);
            for (int i = 0; i < n_data; i++)
                s.push_back(($urandom_range(0, 15) == 0) ? SYM_ERR : int'($urandom_range(0, 1)));
            run_stream(s, 4, -1, 1'b0);
        end

        repeat (10) tick();
        check("scoreboard_empty", 128'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
